// File: rtl/alu_share_ctrl_if.sv
// alu_share_ctrl_if: requester, ALU-pin and response bundle for alu_share_ctrl.
// The slave modport is the controller. The master modport is the surrounding
// logic: it drives the requester ports, the ALU result/flag pins and rsp_ready.
interface alu_share_ctrl_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [4*NUM_REQ-1:0] req_a;
    logic [4*NUM_REQ-1:0] req_b;
    logic [2*NUM_REQ-1:0] req_select;
    logic [3:0]           alu_a;
    logic [3:0]           alu_b;
    logic [1:0]           alu_select;
    logic [3:0]           alu_out;
    logic                 alu_zero;
    logic                 alu_carry;
    logic                 alu_sign;
    logic                 alu_parity;
    logic                 alu_overflow;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [3:0]           rsp_out;
    logic [4:0]           rsp_flags;
    logic                 busy;
    modport master (
        output req_valid, req_a, req_b, req_select,
        output alu_out, alu_zero, alu_carry, alu_sign, alu_parity, alu_overflow,
        output rsp_ready,
        input  req_ready, alu_a, alu_b, alu_select,
        input  rsp_valid, rsp_id, rsp_out, rsp_flags, busy
    );
    modport slave (
        input  req_valid, req_a, req_b, req_select,
        input  alu_out, alu_zero, alu_carry, alu_sign, alu_parity, alu_overflow,
        input  rsp_ready,
        output req_ready, alu_a, alu_b, alu_select,
        output rsp_valid, rsp_id, rsp_out, rsp_flags, busy
    );
endinterface

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin arbiter/sequencer sharing one 4-bit ALU among NUM_REQ requesters.
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   bus (slave)  req_valid/req_ready/req_a/req_b/req_select requester ports,
//                alu_a/alu_b/alu_select registered ALU operands,
//                alu_out plus five flag pins from the ALU,
//                rsp_valid/rsp_ready/rsp_id/rsp_out/rsp_flags response channel,
//                busy (high while executing or presenting a response)
module alu_share_ctrl #(
    parameter int NUM_REQ = 4,
    parameter int ALU_LAT = 1
) (
    input logic clk,
    input logic rst_n,
    alu_share_ctrl_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t          state;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] idx;
    logic            found;
    logic [3:0]      cnt;
    // search upward from last_grant+1 with wrap; first valid index wins
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(last_grant) + k) % NUM_REQ);
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end
    // grant is combinational and only offered in IDLE, so the accept happens the same cycle
    assign bus.req_ready = (rst_n && state == IDLE && found) ?
                           {{(NUM_REQ-1){1'b0}}, 1'b1} << win : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            last_grant     <= ID_W'(NUM_REQ - 1);
            cnt            <= '0;
            bus.alu_a      <= '0;
            bus.alu_b      <= '0;
            bus.alu_select <= '0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_id     <= '0;
            bus.rsp_out    <= '0;
            bus.rsp_flags  <= '0;
            bus.busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    bus.alu_a      <= bus.req_a[4*win +: 4];
                    bus.alu_b      <= bus.req_b[4*win +: 4];
                    bus.alu_select <= bus.req_select[2*win +: 2];
                    bus.rsp_id     <= win;
                    bus.busy       <= 1'b1;
                    cnt            <= 4'(ALU_LAT);
                    state          <= EXEC;
                end
                EXEC: if (cnt == 4'd1) begin
                    bus.rsp_out   <= bus.alu_out;
                    bus.rsp_flags <= {bus.alu_overflow, bus.alu_parity, bus.alu_sign,
                                      bus.alu_carry, bus.alu_zero};
                    bus.rsp_valid <= 1'b1;
                    state         <= RESP;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                RESP: if (bus.rsp_ready) begin
                    // pointer moves on response acceptance, not on grant
                    last_grant    <= bus.rsp_id;
                    bus.rsp_valid <= 1'b0;
                    bus.busy      <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
